mem_access_stage: RTL and testbench

- MEM stage of the RV32I pipeline; sits between the EX/MEM register and the MEM/WB register.
- Consumes regfilemux select codes and fwd-resolved store data.
- Issues one data-memory read/write per load/store, stalls upstream until dmem_resp, aligns/extends load data and registers the writeback result.
- Non-memory instructions pass through with one-cycle latency.

---
 rtl/mem_access_stage.sv | 251 +++++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: RV32I MEM stage between the EX/MEM and MEM/WB registers.
// Issues one data-memory read/write per load/store and holds upstream until
// dmem_resp. It then aligns and extends load data and registers the writeback.
// Non-memory instructions pass through with one cycle of latency.
// Optional build macro: MEM_STAGE_MISALIGN_TRAP_EN. When it is defined,
// misaligned halfword/word accesses are not sent to memory and raise
// misalign_trap instead.
module mem_access_stage #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_load,
    input  logic              ex_store,
    input  logic [2:0]        ex_funct3,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [3:0]        ex_rf_sel,
    input  logic [DATA_W-1:0] ex_wb_data,
    input  logic [4:0]        ex_rd,
    input  logic              ex_ld_regfile,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [ADDR_W-1:0] dmem_address,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [3:0]        dmem_mbe,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_resp,
    output logic              stall,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic              wb_ld_regfile,
    output logic [DATA_W-1:0] wb_data,
    output logic              misalign_trap
);

    localparam logic [3:0] RF_LW  = 4'b0011;
    localparam logic [3:0] RF_LB  = 4'b0101;
    localparam logic [3:0] RF_LBU = 4'b0110;
    localparam logic [3:0] RF_LH  = 4'b0111;
    localparam logic [3:0] RF_LHU = 4'b1000;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    state_e            state_q;

    // Request registers, held stable for the whole ACCESS phase
    logic              dmem_read_q;
    logic              dmem_write_q;
    logic [ADDR_W-1:0] dmem_address_q;
    logic [DATA_W-1:0] dmem_wdata_q;
    logic [3:0]        dmem_mbe_q;
    logic [3:0]        req_rf_sel_q;
    logic [1:0]        req_off_q;
    logic [4:0]        req_rd_q;
    logic              req_ld_q;
    logic              req_is_load_q;

    // Writeback registers
    logic              wb_valid_q;
    logic [4:0]        wb_rd_q;
    logic              wb_ld_regfile_q;
    logic [DATA_W-1:0] wb_data_q;
    logic              misalign_trap_q;

    logic              is_mem;
    logic              misalign;
    logic              accept_mem;
    logic [3:0]        st_mbe;
    logic [DATA_W-1:0] st_wdata;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] ld_data;

    assign is_mem = ex_load | ex_store;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    logic is_half;
    logic is_word;

    // Access size decode; a set ex_load takes priority over ex_store
    always_comb begin
        is_half = 1'b0;
        is_word = 1'b0;
        if (ex_load) begin
            is_half = (ex_rf_sel == RF_LH) || (ex_rf_sel == RF_LHU);
            is_word = (ex_rf_sel == RF_LW);
        end else begin
            is_half = (ex_funct3 == 3'b001);
            is_word = (ex_funct3 == 3'b010);
        end
    end

    assign misalign = (is_half & ex_addr[0]) | (is_word & (|ex_addr[1:0]));
`else
    assign misalign = 1'b0;
`endif

    assign accept_mem = ex_valid & is_mem & ~misalign;

    // Upstream hold: on acceptance and while waiting for the response
    always_comb begin
        stall = 1'b0;
        if (!rst) begin
            if (state_q == IDLE) begin
                stall = accept_mem;
            end else begin
                stall = ~dmem_resp;
            end
        end
    end

    // Store byte enables and lane-replicated write data
    always_comb begin
        st_mbe   = 4'b0000;
        st_wdata = ex_store_data;
        if (ex_load) begin
            st_mbe   = 4'b1111;
            st_wdata = '0;
        end else begin
            case (ex_funct3)
                3'b000: begin
                    st_mbe   = 4'b0001 << ex_addr[1:0];
                    st_wdata = {4{ex_store_data[7:0]}};
                end
                3'b001: begin
                    st_mbe   = ex_addr[1] ? 4'b1100 : 4'b0011;
                    st_wdata = {2{ex_store_data[15:0]}};
                end
                3'b010: begin
                    st_mbe   = 4'b1111;
                    st_wdata = ex_store_data;
                end
                default: begin
                    st_mbe   = 4'b0000;
                    st_wdata = ex_store_data;
                end
            endcase
        end
    end

    // Load lane selection and sign/zero extension
    always_comb begin
        ld_byte = dmem_rdata[7:0];
        case (req_off_q)
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = req_off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (req_rf_sel_q)
            RF_LB:   ld_data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
            RF_LBU:  ld_data = {{(DATA_W-8){1'b0}}, ld_byte};
            RF_LH:   ld_data = {{(DATA_W-16){ld_half[15]}}, ld_half};
            RF_LHU:  ld_data = {{(DATA_W-16){1'b0}}, ld_half};
            default: ld_data = dmem_rdata;
        endcase
    end

    // Stage FSM: request issue, response wait and writeback registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            dmem_read_q     <= 1'b0;
            dmem_write_q    <= 1'b0;
            dmem_address_q  <= '0;
            dmem_wdata_q    <= '0;
            dmem_mbe_q      <= 4'b0000;
            req_rf_sel_q    <= 4'b0000;
            req_off_q       <= 2'b00;
            req_rd_q        <= 5'd0;
            req_ld_q        <= 1'b0;
            req_is_load_q   <= 1'b0;
            wb_valid_q      <= 1'b0;
            wb_rd_q         <= 5'd0;
            wb_ld_regfile_q <= 1'b0;
            wb_data_q       <= '0;
            misalign_trap_q <= 1'b0;
        end else begin
            misalign_trap_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_mem) begin
                        dmem_read_q     <= ex_load;
                        dmem_write_q    <= ~ex_load;
                        dmem_address_q  <= {ex_addr[ADDR_W-1:2], 2'b00};
                        dmem_wdata_q    <= st_wdata;
                        dmem_mbe_q      <= st_mbe;
                        req_rf_sel_q    <= ex_rf_sel;
                        req_off_q       <= ex_addr[1:0];
                        req_rd_q        <= ex_rd;
                        req_ld_q        <= ex_ld_regfile;
                        req_is_load_q   <= ex_load;
                        wb_valid_q      <= 1'b0;
                        wb_ld_regfile_q <= 1'b0;
                        state_q         <= ACCESS;
                    end else if (ex_valid && is_mem) begin
                        // Misaligned access retires as a trapping no-op
                        wb_valid_q      <= 1'b1;
                        wb_rd_q         <= ex_rd;
                        wb_ld_regfile_q <= 1'b0;
                        misalign_trap_q <= 1'b1;
                    end else if (ex_valid) begin
                        wb_valid_q      <= 1'b1;
                        wb_rd_q         <= ex_rd;
                        wb_ld_regfile_q <= ex_ld_regfile & (|ex_rd);
                        wb_data_q       <= ex_wb_data;
                    end else begin
                        wb_valid_q      <= 1'b0;
                        wb_ld_regfile_q <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (dmem_resp) begin
                        dmem_read_q     <= 1'b0;
                        dmem_write_q    <= 1'b0;
                        wb_valid_q      <= 1'b1;
                        wb_rd_q         <= req_rd_q;
                        wb_ld_regfile_q <= req_is_load_q & req_ld_q & (|req_rd_q);
                        if (req_is_load_q) begin
                            wb_data_q <= ld_data;
                        end
                        state_q         <= IDLE;
                    end else begin
                        wb_valid_q      <= 1'b0;
                        wb_ld_regfile_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dmem_read     = dmem_read_q;
    assign dmem_write    = dmem_write_q;
    assign dmem_address  = dmem_address_q;
    assign dmem_wdata    = dmem_wdata_q;
    assign dmem_mbe      = dmem_mbe_q;
    assign wb_valid      = wb_valid_q;
    assign wb_rd         = wb_rd_q;
    assign wb_ld_regfile = wb_ld_regfile_q;
    assign wb_data       = wb_data_q;
    assign misalign_trap = misalign_trap_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: a directed vector table followed by random
// operations checked against a behavioural model of the stage.
module tb_mem_access_stage;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        ex_load;
    logic        ex_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr;
    logic [31:0] ex_store_data;
    logic [3:0]  ex_rf_sel;
    logic [31:0] ex_wb_data;
    logic [4:0]  ex_rd;
    logic        ex_ld_regfile;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_mbe;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_ld_regfile;
    logic [31:0] wb_data;
    logic        misalign_trap;

    int checks;
    int errors;
    int cur_idx;

    mem_access_stage dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_store_data(ex_store_data),
        .ex_rf_sel(ex_rf_sel), .ex_wb_data(ex_wb_data), .ex_rd(ex_rd),
        .ex_ld_regfile(ex_ld_regfile),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
        .dmem_wdata(dmem_wdata), .dmem_mbe(dmem_mbe), .dmem_rdata(dmem_rdata),
        .dmem_resp(dmem_resp), .stall(stall),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_ld_regfile(wb_ld_regfile),
        .wb_data(wb_data), .misalign_trap(misalign_trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        load;
        logic        store;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [3:0]  rf;
        logic [31:0] wbd;
        logic [4:0]  rd;
        logic        ld;
        int          lat;
        logic [31:0] rdata;
        logic        e_trap;
        logic [31:0] e_addr;
        logic [3:0]  e_mbe;
        logic [31:0] e_wdata;
        logic [31:0] e_wb;
        logic        e_ld;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s op=%0d actual=%h expected=%h", name, cur_idx, act, exp);
        end
    endtask

    function automatic vec_t row(input logic l, input logic s, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] sdata,
                                 input logic [3:0] rf, input logic [31:0] wbd,
                                 input logic [4:0] rd, input logic ld, input int lat,
                                 input logic [31:0] rdata, input logic e_trap,
                                 input logic [31:0] e_addr, input logic [3:0] e_mbe,
                                 input logic [31:0] e_wdata, input logic [31:0] e_wb,
                                 input logic e_ld);
        vec_t v;
        v.load = l; v.store = s; v.f3 = f3; v.addr = addr; v.sdata = sdata;
        v.rf = rf; v.wbd = wbd; v.rd = rd; v.ld = ld; v.lat = lat; v.rdata = rdata;
        v.e_trap = e_trap; v.e_addr = e_addr; v.e_mbe = e_mbe; v.e_wdata = e_wdata;
        v.e_wb = e_wb; v.e_ld = e_ld;
        return v;
    endfunction

    // Reference model: expected results from the instruction semantics
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int unsigned off;
        int unsigned b;
        int unsigned h;
        logic half_acc;
        logic word_acc;
        r = v;
        off = v.addr % 4;
        half_acc = v.load ? (v.rf == 4'b0111 || v.rf == 4'b1000) : (v.f3 == 3'd1);
        word_acc = v.load ? (v.rf == 4'b0011) : (v.f3 == 3'd2);
        r.e_trap = 1'b0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        if ((v.load || v.store) && ((half_acc && (off % 2) != 0) || (word_acc && off != 0)))
            r.e_trap = 1'b1;
`endif
        r.e_addr = v.addr - off;
        case (v.f3)
            3'd0: begin r.e_mbe = 4'(1 << off);           r.e_wdata = (v.sdata % 256) * 32'h01010101; end
            3'd1: begin r.e_mbe = 4'(3 << (2 * (off / 2))); r.e_wdata = (v.sdata % 65536) * 32'h00010001; end
            3'd2: begin r.e_mbe = 4'hF;                   r.e_wdata = v.sdata; end
            default: begin r.e_mbe = 4'h0;                r.e_wdata = v.sdata; end
        endcase
        b = (v.rdata >> (8 * off)) % 256;
        h = (v.rdata >> (16 * (off / 2))) % 65536;
        if (!v.load) r.e_wb = v.wbd;
        else case (v.rf)
            4'b0101: r.e_wb = (b >= 128) ? 32'(b) + 32'hFFFFFF00 : 32'(b);
            4'b0110: r.e_wb = 32'(b);
            4'b0111: r.e_wb = (h >= 32768) ? 32'(h) + 32'hFFFF0000 : 32'(h);
            4'b1000: r.e_wb = 32'(h);
            default: r.e_wb = v.rdata;
        endcase
        r.e_ld = (r.e_trap || (v.store && !v.load)) ? 1'b0 : (v.ld && v.rd != 5'd0);
        return r;
    endfunction

    // Drive one instruction at a negedge, play memory, check WB at the negedge after it retires
    task automatic apply(input vec_t v);
        logic mem;
        ex_valid = 1'b1; ex_load = v.load; ex_store = v.store; ex_funct3 = v.f3;
        ex_addr = v.addr; ex_store_data = v.sdata; ex_rf_sel = v.rf;
        ex_wb_data = v.wbd; ex_rd = v.rd; ex_ld_regfile = v.ld;
        mem = (v.load || v.store) && !v.e_trap;
        #1;
        chk("stall_accept", 32'(stall), 32'(mem));
        @(posedge clk);
        if (mem) begin
            for (int c = 1; c <= v.lat; c++) begin
                @(negedge clk);
                chk("dmem_read", 32'(dmem_read), 32'(v.load));
                chk("dmem_write", 32'(dmem_write), 32'(!v.load));
                chk("dmem_address", dmem_address, v.e_addr);
                if (!v.load) begin
                    chk("dmem_mbe", 32'(dmem_mbe), 32'(v.e_mbe));
                    if (v.f3 <= 3'd2) chk("dmem_wdata", dmem_wdata, v.e_wdata);
                end
                if (c == v.lat) begin
                    dmem_resp = 1'b1;
                    dmem_rdata = v.rdata;
                end else begin
                    dmem_rdata = $urandom;
                end
                #1;
                chk("stall_access", 32'(stall), 32'(c != v.lat));
                @(posedge clk);
            end
        end
        @(negedge clk);
        dmem_resp = 1'b0;
        ex_valid = 1'b0;
        ex_load = 1'b0;
        ex_store = 1'b0;
        chk("wb_valid", 32'(wb_valid), 32'd1);
        chk("wb_ld_regfile", 32'(wb_ld_regfile), 32'(v.e_ld));
        chk("misalign_trap", 32'(misalign_trap), 32'(v.e_trap));
        chk("req_released", 32'({dmem_read, dmem_write}), 32'd0);
        if (!v.e_trap) chk("wb_rd", 32'(wb_rd), 32'(v.rd));
        if (!v.e_trap && !(v.store && !v.load)) chk("wb_data", wb_data, v.e_wb);
        cur_idx++;
    endtask

    task automatic idle_cycle(input logic resp);
        ex_valid = 1'b0;
        dmem_resp = resp;
        @(posedge clk);
        @(negedge clk);
        dmem_resp = 1'b0;
        chk("bubble_wb_valid", 32'(wb_valid), 32'd0);
        chk("bubble_no_req", 32'({dmem_read, dmem_write}), 32'd0);
    endtask

    vec_t tbl[$];

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int kind;
        checks = 0; errors = 0; cur_idx = 0;
        rst = 1'b1; ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_funct3 = 3'd0;
        ex_addr = '0; ex_store_data = '0; ex_rf_sel = 4'd0; ex_wb_data = '0;
        ex_rd = 5'd0; ex_ld_regfile = 1'b0; dmem_rdata = '0; dmem_resp = 1'b0;

        // Expected columns: trap, dmem addr, mbe, wdata, wb_data, wb_ld_regfile
        tbl.push_back(row(1,0,3'd0,32'h1003,0,4'b0101,0,5'd5,1,3,32'h80AABBCC, 0,32'h1000,0,0,32'hFFFFFF80,1));
        tbl.push_back(row(0,1,3'd1,32'h2002,32'h1234ABCD,0,0,5'd8,1,1,0, 0,32'h2000,4'b1100,32'hABCDABCD,0,0));
        tbl.push_back(row(1,0,3'd0,32'h2002,0,4'b1000,0,5'd6,1,1,32'h80010000, 0,32'h2000,0,0,32'h00008001,1));
        tbl.push_back(row(1,0,3'd0,32'h2002,0,4'b0111,0,5'd7,1,2,32'h80010000, 0,32'h2000,0,0,32'hFFFF8001,1));
        tbl.push_back(row(0,0,3'd0,32'h0,0,4'b0000,32'h11111111,5'd1,1,0,0, 0,0,0,0,32'h11111111,1));
        tbl.push_back(row(0,0,3'd0,32'h0,0,4'b0000,32'h22222222,5'd2,1,0,0, 0,0,0,0,32'h22222222,1));
        tbl.push_back(row(0,0,3'd0,32'h0,0,4'b0000,32'h33333333,5'd3,1,0,0, 0,0,0,0,32'h33333333,1));
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        tbl.push_back(row(1,0,3'd0,32'h1002,0,4'b0011,0,5'd9,1,2,32'hDEADBEEF, 1,32'h1000,0,0,32'hDEADBEEF,0));
        tbl.push_back(row(1,0,3'd0,32'h2001,0,4'b0111,0,5'd11,1,1,32'h8001F234, 1,32'h2000,0,0,32'hFFFFF234,0));
`else
        tbl.push_back(row(1,0,3'd0,32'h1002,0,4'b0011,0,5'd9,1,2,32'hDEADBEEF, 0,32'h1000,0,0,32'hDEADBEEF,1));
        tbl.push_back(row(1,0,3'd0,32'h2001,0,4'b0111,0,5'd11,1,1,32'h8001F234, 0,32'h2000,0,0,32'hFFFFF234,1));
`endif
        tbl.push_back(row(0,1,3'd0,32'h3001,32'h55667788,0,0,5'd12,0,1,0, 0,32'h3000,4'b0010,32'h88888888,0,0));
        tbl.push_back(row(0,1,3'd2,32'h4000,32'hCAFEF00D,0,0,5'd13,0,2,0, 0,32'h4000,4'b1111,32'hCAFEF00D,0,0));
        tbl.push_back(row(0,1,3'd3,32'h5000,32'h01020304,0,0,5'd14,0,1,0, 0,32'h5000,4'b0000,32'h01020304,0,0));
        tbl.push_back(row(1,1,3'd2,32'h6004,32'hFFFFFFFF,4'b0011,0,5'd10,1,1,32'h0BADC0DE, 0,32'h6004,0,0,32'h0BADC0DE,1));
        tbl.push_back(row(1,0,3'd0,32'h7000,0,4'b0011,0,5'd0,1,2,32'h12345678, 0,32'h7000,0,0,32'h12345678,0));
        tbl.push_back(row(0,0,3'd0,32'h0,0,4'b0000,32'hA5A5A5A5,5'd4,0,0,0, 0,0,0,0,32'hA5A5A5A5,0));
        tbl.push_back(row(1,0,3'd0,32'h1001,0,4'b0110,0,5'd15,1,1,32'h80AABBCC, 0,32'h1000,0,0,32'h000000BB,1));

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_dmem_read", 32'(dmem_read), 32'd0);
        chk("rst_dmem_write", 32'(dmem_write), 32'd0);
        chk("rst_dmem_address", dmem_address, 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_misalign_trap", 32'(misalign_trap), 32'd0);
        rst = 1'b0;

        foreach (tbl[i]) apply(tbl[i]);

        // Response while idle must be ignored
        idle_cycle(1'b1);

        // Reset while in ACCESS, then a late response
        v = row(1,0,3'd0,32'h8000,0,4'b0011,0,5'd3,1,1,0, 0,32'h8000,0,0,0,0);
        ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_addr = v.addr;
        ex_rf_sel = v.rf; ex_rd = v.rd; ex_ld_regfile = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_seq_read", 32'(dmem_read), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_seq_stall", 32'(stall), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_seq_read_clr", 32'(dmem_read), 32'd0);
        chk("rst_seq_wb_valid", 32'(wb_valid), 32'd0);
        rst = 1'b0;
        ex_valid = 1'b0; ex_load = 1'b0;
        dmem_resp = 1'b1;
        dmem_rdata = 32'hFEEDFACE;
        #1;
        chk("late_resp_stall", 32'(stall), 32'd0);
        @(posedge clk);
        @(negedge clk);
        dmem_resp = 1'b0;
        chk("late_resp_wb_valid", 32'(wb_valid), 32'd0);
        chk("late_resp_no_req", 32'({dmem_read, dmem_write}), 32'd0);

        // Random operations against the model
        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 8);
            v = row(0,0,3'd0,$urandom,$urandom,4'(($urandom_range(0,1) == 0) ? 4'b0000 : 4'b1010),
                    $urandom,5'($urandom),1'($urandom),$urandom_range(1,3),$urandom, 0,0,0,0,0,0);
            case (kind)
                1: begin v.load = 1; v.rf = 4'b0101; end
                2: begin v.load = 1; v.rf = 4'b0110; end
                3: begin v.load = 1; v.rf = 4'b0111; end
                4: begin v.load = 1; v.rf = 4'b1000; end
                5: begin v.load = 1; v.rf = 4'b0011; end
                6: begin v.store = 1; v.f3 = 3'd0; end
                7: begin v.store = 1; v.f3 = 3'd1; end
                8: begin v.store = 1; v.f3 = 3'd2; end
                default: ;
            endcase
            apply(model(v));
            if ($urandom_range(0, 4) == 0) idle_cycle(1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
